real_clock_hms: RTL and testbench

//  Parametrised real-time clock core with a prescaler, seconds, minutes and hours, and a selectable 24h or 12h hour mode.

---
 rtl/real_clock_hms.sv | 158 +++++++++++++++
 tb/tb_real_clock_hms.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/real_clock_hms.sv
// Real-time clock core: prescaler, sec/min/hr (24h or 12h+pm), hh:mm alarm, pause, range-checked loads.
// Latency: loads and advances land on the next clk edge; alarm_pulse/load_err are registered one-cycle strobes.
// Backpressure: none; every write is accepted or rejected in the cycle it is presented.
module real_clock_hms #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter bit HOUR_24       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] addrs,
  input  logic [5:0] data_in,
  output logic [5:0] seconds_out,
  output logic [5:0] minutes_out,
  output logic [4:0] hours_out,
  output logic       pm_out,
  output logic       tick_1hz,
  output logic       alarm_pulse,
  output logic       load_err
);

  localparam int             PW      = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0]  PRE_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [4:0]     HR_RST  = HOUR_24 ? 5'd0 : 5'd12;

  localparam logic [2:0] A_SEC  = 3'd0;
  localparam logic [2:0] A_MIN  = 3'd1;
  localparam logic [2:0] A_HR   = 3'd2;
  localparam logic [2:0] A_AMIN = 3'd3;
  localparam logic [2:0] A_AHR  = 3'd4;
  localparam logic [2:0] A_CTRL = 3'd5;

  logic [PW-1:0] presc;
  logic [5:0]    sec, min, amin;
  logic [4:0]    hr, ahr;
  logic          pm, apm;
  logic          alarm_en, run;

  logic          hr_ok, addr_ok, wr_ok;
  logic          ld_sec, ld_min, ld_hr, ld_amin, ld_ahr, ld_ctrl;
  logic [4:0]    hr_load;
  logic          pm_load;
  logic          carry_min, carry_hr;
  logic [5:0]    sec_n, min_n;
  logic [4:0]    hr_n;
  logic          pm_n;
  logic          alarm_hit;

  assign tick_1hz = run & (presc == PRE_MAX);

  // 12h hour writes carry the pm flag in bit 5; 24h writes are plain 0..23.
  assign hr_ok   = HOUR_24 ? (data_in <= 6'd23)
                           : ((data_in[4:0] != 5'd0) && (data_in[4:0] <= 5'd12));
  assign hr_load = data_in[4:0];
  assign pm_load = HOUR_24 ? 1'b0 : data_in[5];

  always_comb begin
    addr_ok = 1'b0;
    case (addrs)
      A_SEC, A_MIN, A_AMIN: addr_ok = (data_in <= 6'd59);
      A_HR, A_AHR:          addr_ok = hr_ok;
      A_CTRL:               addr_ok = 1'b1;
      default:              addr_ok = 1'b0;
    endcase
  end

  assign wr_ok   = load & addr_ok;
  assign ld_sec  = wr_ok & (addrs == A_SEC);
  assign ld_min  = wr_ok & (addrs == A_MIN);
  assign ld_hr   = wr_ok & (addrs == A_HR);
  assign ld_amin = wr_ok & (addrs == A_AMIN);
  assign ld_ahr  = wr_ok & (addrs == A_AHR);
  assign ld_ctrl = wr_ok & (addrs == A_CTRL);

  // A loaded field swallows its own carry-out, so higher fields stay put.
  assign carry_min = tick_1hz & (sec == 6'd59) & ~ld_sec;
  assign carry_hr  = carry_min & (min == 6'd59) & ~ld_min;

  always_comb begin
    sec_n = sec;
    if (ld_sec)
      sec_n = data_in;
    else if (tick_1hz)
      sec_n = (sec == 6'd59) ? 6'd0 : sec + 6'd1;
  end

  always_comb begin
    min_n = min;
    if (ld_min)
      min_n = data_in;
    else if (carry_min)
      min_n = (min == 6'd59) ? 6'd0 : min + 6'd1;
  end

  always_comb begin
    hr_n = hr;
    pm_n = pm;
    if (ld_hr) begin
      hr_n = hr_load;
      pm_n = pm_load;
    end else if (carry_hr) begin
      if (HOUR_24) begin
        hr_n = (hr == 5'd23) ? 5'd0 : hr + 5'd1;
      end else begin
        hr_n = (hr == 5'd12) ? 5'd1 : hr + 5'd1;
        if (hr == 5'd11)
          pm_n = ~pm;
      end
    end
  end

  assign alarm_hit = tick_1hz & ~(ld_sec | ld_min | ld_hr) & alarm_en & (sec_n == 6'd0)
                   & (min_n == amin) & (hr_n == ahr) & (pm_n == apm);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc       <= '0;
      sec         <= 6'd0;
      min         <= 6'd0;
      hr          <= HR_RST;
      pm          <= 1'b0;
      amin        <= 6'd0;
      ahr         <= HR_RST;
      apm         <= 1'b0;
      alarm_en    <= 1'b0;
      run         <= 1'b1;
      alarm_pulse <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      if (ld_sec)
        presc <= '0;
      else if (run)
        presc <= (presc == PRE_MAX) ? '0 : presc + 1'b1;
      sec <= sec_n;
      min <= min_n;
      hr  <= hr_n;
      pm  <= pm_n;
      if (ld_amin)
        amin <= data_in;
      if (ld_ahr) begin
        ahr <= hr_load;
        apm <= pm_load;
      end
      if (ld_ctrl) begin
        alarm_en <= data_in[0];
        run      <= data_in[1];
      end
      alarm_pulse <= alarm_hit;
      load_err    <= load & ~addr_ok;
    end
  end

  assign seconds_out = sec;
  assign minutes_out = min;
  assign hours_out   = hr;
  assign pm_out      = pm;

endmodule

// File: tb/tb_real_clock_hms.sv
// Scoreboard bench for real_clock_hms: a 24h and a 12h instance share stimulus; a seconds-of-day
// reference model predicts every post-edge output and a monitor compares them each cycle.
module tb_real_clock_hms;

  localparam int T = 4;

  typedef struct {
    int sec, min, hr, pm, tick, alarm, err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [2:0] addrs = 3'd0;
  logic [5:0] data_in = 6'd0;

  logic [5:0] s24, m24, s12, m12;
  logic [4:0] h24, h12;
  logic       pm24, t24, a24, e24, pm12, t12, a12, e12;

  real_clock_hms #(.TICKS_PER_SEC(T), .HOUR_24(1'b1)) u24 (
    .clk(clk), .reset(rst_n), .load(load), .addrs(addrs), .data_in(data_in),
    .seconds_out(s24), .minutes_out(m24), .hours_out(h24), .pm_out(pm24),
    .tick_1hz(t24), .alarm_pulse(a24), .load_err(e24)
  );

  real_clock_hms #(.TICKS_PER_SEC(T), .HOUR_24(1'b0)) u12 (
    .clk(clk), .reset(rst_n), .load(load), .addrs(addrs), .data_in(data_in),
    .seconds_out(s12), .minutes_out(m12), .hours_out(h12), .pm_out(pm12),
    .tick_1hz(t12), .alarm_pulse(a12), .load_err(e12)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  exp_t q12[$];
  exp_t q24[$];
  int n_tick[2], n_alarm[2], n_err[2];

  // Reference model, index 0 = 12h instance, 1 = 24h instance. Time kept as seconds of day.
  int tod[2], am[2], ah[2], pc[2];
  bit en[2], run[2];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int md = 0; md < 2; md++) begin
      tod[md] = 0; am[md] = 0; ah[md] = 0; pc[md] = 0;
      en[md] = 1'b0; run[md] = 1'b1;
    end
  endtask

  task automatic model_step(input int md, input bit ld, input int a, input int d, output exp_t e);
    bit tick, ok, tl, en_o, run_o;
    int hv, cur, nxt, ch, cm, nh, nm, ns, rh, rm, rs, am_o, ah_o;
    tick = run[md] && (pc[md] == T - 1);
    en_o = en[md]; run_o = run[md]; am_o = am[md]; ah_o = ah[md];
    hv = 0;
    case (a)
      0, 1, 3: ok = (d <= 59);
      2, 4: begin
        if (md == 1) begin
          ok = (d <= 23);
          hv = d;
        end else begin
          ok = ((d % 32) >= 1) && ((d % 32) <= 12);
          hv = ((d % 32) % 12) + ((d >= 32) ? 12 : 0);
        end
      end
      5: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    cur = tod[md];
    nxt = tick ? (cur + 1) % 86400 : cur;
    ch = cur / 3600; cm = (cur / 60) % 60;
    nh = nxt / 3600; nm = (nxt / 60) % 60; ns = nxt % 60;
    rh = nh; rm = nm; rs = ns; tl = 1'b0;
    if (ld && ok) begin
      case (a)
        0: begin rh = ch; rm = cm; rs = d; tl = 1'b1; end
        1: begin rh = ch; rm = d; tl = 1'b1; end
        2: begin rh = hv; tl = 1'b1; end
        3: am[md] = d;
        4: ah[md] = hv;
        default: begin en[md] = (d % 2) == 1; run[md] = ((d / 2) % 2) == 1; end
      endcase
    end
    e.alarm = (tick && !tl && en_o && rs == 0 && rm == am_o && rh == ah_o) ? 1 : 0;
    if (ld && ok && a == 0) pc[md] = 0;
    else if (run_o) pc[md] = (pc[md] + 1) % T;
    tod[md] = rh * 3600 + rm * 60 + rs;
    e.sec  = rs;
    e.min  = rm;
    e.hr   = (md == 1) ? rh : ((rh % 12 == 0) ? 12 : rh % 12);
    e.pm   = (md == 1) ? 0 : ((rh >= 12) ? 1 : 0);
    e.tick = (run[md] && pc[md] == T - 1) ? 1 : 0;
    e.err  = (ld && !ok) ? 1 : 0;
  endtask

  task automatic drive(input bit ld, input int a, input int d);
    exp_t e;
    load = ld; addrs = 3'(a); data_in = 6'(d);
    model_step(0, ld, a, d, e); q12.push_back(e);
    model_step(1, ld, a, d, e); q24.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0);
  endtask

  task automatic cmp(input string tag, input exp_t e, input int s, input int m, input int h,
                     input int p, input int t, input int a, input int er);
    check({tag, ".sec"}, s, e.sec);
    check({tag, ".min"}, m, e.min);
    check({tag, ".hr"}, h, e.hr);
    check({tag, ".pm"}, p, e.pm);
    check({tag, ".tick"}, t, e.tick);
    check({tag, ".alarm"}, a, e.alarm);
    check({tag, ".err"}, er, e.err);
  endtask

  // Asserts reset away from any clock edge and checks the asynchronous clear.
  task automatic do_reset();
    @(posedge clk); #3;
    load = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst.h24.sec", int'(s24), 0); check("rst.h24.min", int'(m24), 0);
    check("rst.h24.hr", int'(h24), 0);  check("rst.h24.pm", int'(pm24), 0);
    check("rst.h24.tick", int'(t24), 0); check("rst.h24.alarm", int'(a24), 0);
    check("rst.h24.err", int'(e24), 0);
    check("rst.h12.sec", int'(s12), 0); check("rst.h12.min", int'(m12), 0);
    check("rst.h12.hr", int'(h12), 12); check("rst.h12.pm", int'(pm12), 0);
    check("rst.h12.tick", int'(t12), 0); check("rst.h12.alarm", int'(a12), 0);
    check("rst.h12.err", int'(e12), 0);
    @(negedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q24.size() > 0) begin
        e = q24.pop_front();
        cmp("h24", e, int'(s24), int'(m24), int'(h24), int'(pm24), int'(t24), int'(a24), int'(e24));
        n_tick[1] += int'(t24); n_alarm[1] += int'(a24); n_err[1] += int'(e24);
      end
      if (q12.size() > 0) begin
        e = q12.pop_front();
        cmp("h12", e, int'(s12), int'(m12), int'(h12), int'(pm12), int'(t12), int'(a12), int'(e12));
        n_tick[0] += int'(t12); n_alarm[0] += int'(a12); n_err[0] += int'(e12);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap_t, snap_a24, snap_a12, snap_e24, snap_e12;
    for (int md = 0; md < 2; md++) begin
      n_tick[md] = 0; n_alarm[md] = 0; n_err[md] = 0;
    end
    model_reset();

    // Free run after reset: one tick every T cycles.
    do_reset();
    snap_t = n_tick[1];
    idle(12);
    check("run12.ticks", n_tick[1] - snap_t, 3);
    check("run12.h24.sec", int'(s24), 3);
    check("run12.h12.sec", int'(s12), 3);

    // Full carry chain 23:59:59 -> 00:00:00 (12h instance rejects hr=23).
    drive(1'b1, 0, 59); drive(1'b1, 1, 59); drive(1'b1, 2, 23); idle(6);

    // 12h: 11:59:59 AM -> 12 PM, then 12:59:59 PM -> 1 PM.
    drive(1'b1, 0, 59); drive(1'b1, 1, 59); drive(1'b1, 2, 11); idle(6);
    drive(1'b1, 0, 59); drive(1'b1, 1, 59); drive(1'b1, 2, 32 + 12); idle(6);

    // Out-of-range writes.
    snap_e24 = n_err[1]; snap_e12 = n_err[0];
    drive(1'b1, 1, 60); drive(1'b1, 2, 24); idle(2);
    check("oor.h24.errs", n_err[1] - snap_e24, 2);
    check("oor.h12.errs", n_err[0] - snap_e12, 2);

    // Alarm at 07:30, enabled then disabled.
    do_reset();
    snap_a24 = n_alarm[1]; snap_a12 = n_alarm[0];
    drive(1'b1, 4, 7); drive(1'b1, 3, 30); drive(1'b1, 5, 3);
    drive(1'b1, 0, 59); drive(1'b1, 1, 29); drive(1'b1, 2, 7); idle(6);
    check("alarm_on.h24.pulses", n_alarm[1] - snap_a24, 1);
    check("alarm_on.h12.pulses", n_alarm[0] - snap_a12, 1);
    snap_a24 = n_alarm[1]; snap_a12 = n_alarm[0];
    drive(1'b1, 5, 2);
    drive(1'b1, 0, 59); drive(1'b1, 1, 29); drive(1'b1, 2, 7); idle(6);
    check("alarm_off.h24.pulses", n_alarm[1] - snap_a24, 0);
    check("alarm_off.h12.pulses", n_alarm[0] - snap_a12, 0);

    // Pause, write while paused, resume, then reset mid-second.
    drive(1'b1, 5, 0);
    snap_t = n_tick[1];
    idle(20);
    check("pause.ticks", n_tick[1] - snap_t, 0);
    drive(1'b1, 1, 41); idle(3);
    drive(1'b1, 5, 2); idle(6);
    do_reset();

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      bit ld;
      int a, d;
      if (i == 300) do_reset();
      ld = ($urandom_range(0, 5) == 0);
      a  = $urandom_range(0, 7);
      if ($urandom_range(0, 4) == 0) begin
        d = $urandom_range(0, 63);
      end else begin
        case (a)
          0, 1, 3: d = $urandom_range(0, 59);
          2, 4:    d = $urandom_range(0, 1) ? $urandom_range(0, 23)
                                            : $urandom_range(1, 12) + ($urandom_range(0, 1) ? 32 : 0);
          5:       d = (($urandom_range(0, 5) == 0) ? 0 : 2) + $urandom_range(0, 1);
          default: d = $urandom_range(0, 63);
        endcase
      end
      drive(ld, a, d);
    end
    load = 1'b0;

    @(posedge clk); #2;
    check("q24.drained", q24.size(), 0);
    check("q12.drained", q12.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
